// File: rtl/fifo_rd_streamer.sv
// Read-domain consumer for the dual-clock FIFO: issues reads against a 2-entry skid buffer,
// presents a bubble-free valid/ready stream, frames fixed-length packets and counts words.
module fifo_rd_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_r_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  word_count
);
    localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    occ_t                  occ;
    logic                  inflight;
    logic                  wr_idx;
    logic                  rd_idx;
    logic [DATA_WIDTH-1:0] mem [2];
    logic [BEAT_W-1:0]     beat_cnt;
    logic                  push;
    logic                  pop;
    logic [2:0]            credit;

    assign pop  = m_valid & m_ready;
    assign push = inflight;

    // Buffered words plus the one in flight, less the one leaving now; one more read is safe only if this is <= 1.
    assign credit    = 3'(occ) + 3'(inflight) - 3'(pop);
    assign fifo_r_en = rrst_n & enable & ~fifo_empty & (credit <= 3'd1);

    assign m_valid = (occ != EMPTY);
    assign m_data  = mem[rd_idx];
    assign m_last  = m_valid & (beat_cnt == LAST_BEAT);

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            occ        <= EMPTY;
            inflight   <= 1'b0;
            wr_idx     <= 1'b0;
            rd_idx     <= 1'b0;
            mem[0]     <= '0;
            mem[1]     <= '0;
            beat_cnt   <= '0;
            word_count <= '0;
        end else begin
            inflight <= fifo_r_en;
            if (push) begin
                mem[wr_idx] <= fifo_data;
                wr_idx      <= ~wr_idx;
            end
            if (pop) begin
                rd_idx     <= ~rd_idx;
                word_count <= word_count + CNT_WIDTH'(1);
                beat_cnt   <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BEAT_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= (occ == EMPTY) ? ONE : TWO;
                2'b01:   occ <= (occ == TWO) ? ONE : EMPTY;
                default: occ <= occ;
            endcase
        end
    end
endmodule
